homomorphic_seq: RTL

//  Sequencer in front of the homomorphic envelope datapath (log -> Butterworth LP -> exp).

---
 rtl/homomorphic_seq_if.sv | 32 +++
 rtl/homomorphic_seq.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/homomorphic_seq_if.sv
// ----------------------------------------------------------------------------
// homomorphic_seq_if
//   Bundles the three streaming paths around the homomorphic sequencer:
//     in_*   : upstream PCG sample stream (valid/ready)
//     dp_*   : datapath drive (sample, active-low datapath reset) and the
//              datapath return (result word plus its write-enable strobe)
//     out_*  : result FIFO head towards the bus bridge (valid/ready)
//   master : the environment side (sample source, datapath, bus bridge)
//   slave  : the sequencer side
// ----------------------------------------------------------------------------
interface homomorphic_seq_if;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic [31:0] dp_data;
  logic        dp_rst;
  logic [31:0] dp_out;
  logic        dp_we;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;

  modport master (
    output in_valid, in_data, dp_out, dp_we, out_ready,
    input  in_ready, dp_data, dp_rst, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, dp_out, dp_we, out_ready,
    output in_ready, dp_data, dp_rst, out_valid, out_data
  );
endinterface

// File: rtl/homomorphic_seq.sv
// ----------------------------------------------------------------------------
// homomorphic_seq
//   Sequencer in front of the homomorphic envelope datapath
//   (log -> Butterworth LP -> exp). For one block of block_len samples it
//   clears the datapath filter state, issues one sample at a time, waits for
//   the datapath write strobe and queues each result in an output FIFO.
//
// Ports
//   clk_i          clock
//   rst_ni         asynchronous reset, active low
//   start_i        1-cycle start pulse, honoured only in IDLE or DONE
//   block_len_i    samples per block, captured on an accepted start (0 = no-op)
//   bus            homomorphic_seq_if.slave: sample in, datapath, FIFO out
//   busy_o         block in progress (not IDLE/DONE)
//   done_o         sticky block-end flag, cleared on accepted start
//   err_o          sticky datapath timeout flag, cleared on accepted start
//   sample_cnt_o   results pushed in the current block (saturating)
//
// Configuration
//   HOM_SEQ_TIMEOUT_EN : when defined, WAIT_DP gives up after TIMEOUT cycles
//   without dp_we, raises err, pulses dp_rst low for one cycle and ends the
//   block. When undefined err_o is tied low and WAIT_DP waits indefinitely.
// ----------------------------------------------------------------------------
module homomorphic_seq #(
  parameter int          FIFO_DEPTH = 8,
  parameter int          CLR_CYCLES = 4,
  parameter logic [31:0] MIN_MAG    = 32'h1,
  parameter int          TIMEOUT    = 1024
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic [15:0]             block_len_i,
  homomorphic_seq_if.slave        bus,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o,
  output logic [15:0]             sample_cnt_o
);

  localparam int DATA_W = 32;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FILL_W = PTR_W + 1;
  localparam int CLR_W  = $clog2(CLR_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_WAIT_IN,
    S_WAIT_DP,
    S_DONE
  } state_t;

  state_t                    state_q, state_d;
  logic [15:0]               len_q, len_d;
  logic [15:0]               sample_cnt_q, sample_cnt_d;
  logic                      done_q, done_d;
  logic signed [DATA_W-1:0]  dp_data_q, dp_data_d;
  logic                      dp_rst_q, dp_rst_d;
  logic [CLR_W-1:0]          clr_cnt_q, clr_cnt_d;
  logic                      push_d;

  // Result staging register: one cycle between dp_we and the FIFO write.
  logic                      push_vld_q;
  logic [DATA_W-1:0]         push_data_q;

  logic [DATA_W-1:0]         mem [FIFO_DEPTH];
  logic [PTR_W-1:0]          wr_ptr_q, rd_ptr_q;
  logic [FILL_W-1:0]         fill_q;
  logic [FILL_W:0]           occupancy;
  logic                      slot_free, pop, out_valid, in_ready;

`ifdef HOM_SEQ_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0]          tmo_cnt_q, tmo_cnt_d;
  logic                      err_q, err_d;
`endif

  // Sign-preserving magnitude floor; keeps the log stage away from ln(0).
  // The magnitude is handled unsigned so the most negative input stays legal.
  function automatic logic signed [DATA_W-1:0] clamp_mag(
    input logic signed [DATA_W-1:0] x
  );
    logic [DATA_W-1:0] mag;
    mag = x[DATA_W-1] ? unsigned'(-x) : unsigned'(x);
    if (mag < MIN_MAG) mag = MIN_MAG;
    return x[DATA_W-1] ? -signed'(mag) : signed'(mag);
  endfunction

  // A slot counts as taken once a result is staged, so issue never
  // outruns FIFO space.
  assign occupancy = {1'b0, fill_q} + {{FILL_W{1'b0}}, push_vld_q};
  assign slot_free = occupancy < (FILL_W + 1)'(FIFO_DEPTH);
  assign out_valid = (fill_q != '0);
  assign pop       = out_valid && bus.out_ready;
  assign in_ready  = (state_q == S_WAIT_IN) && slot_free;

  assign bus.in_ready  = in_ready;
  assign bus.dp_data   = dp_data_q;
  assign bus.dp_rst    = dp_rst_q;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_valid ? mem[rd_ptr_q] : '0;

  assign busy_o       = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done_o       = done_q;
  assign sample_cnt_o = sample_cnt_q;
`ifdef HOM_SEQ_TIMEOUT_EN
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    sample_cnt_d = sample_cnt_q;
    done_d       = done_q;
    dp_data_d    = dp_data_q;
    dp_rst_d     = dp_rst_q;
    clr_cnt_d    = clr_cnt_q;
    push_d       = 1'b0;
`ifdef HOM_SEQ_TIMEOUT_EN
    tmo_cnt_d    = tmo_cnt_q;
    err_d        = err_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        // Ends the one-cycle timeout pulse; no effect after a normal block.
        if (state_q == S_DONE) dp_rst_d = 1'b1;
        if (start_i) begin
          len_d        = block_len_i;
          sample_cnt_d = '0;
          done_d       = 1'b0;
`ifdef HOM_SEQ_TIMEOUT_EN
          err_d        = 1'b0;
`endif
          if (block_len_i == 16'd0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d   = S_CLR;
            clr_cnt_d = '0;
            dp_rst_d  = 1'b0;
          end
        end
      end
      S_CLR: begin
        if (clr_cnt_q == CLR_W'(CLR_CYCLES - 1)) begin
          dp_rst_d = 1'b1;
          state_d  = S_WAIT_IN;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      S_WAIT_IN: begin
        if (bus.in_valid && in_ready) begin
          dp_data_d = clamp_mag(signed'(bus.in_data));
          state_d   = S_WAIT_DP;
`ifdef HOM_SEQ_TIMEOUT_EN
          tmo_cnt_d = '0;
`endif
        end
      end
      S_WAIT_DP: begin
        if (bus.dp_we) begin
          push_d       = 1'b1;
          sample_cnt_d = (sample_cnt_q == 16'hFFFF) ? sample_cnt_q
                                                    : sample_cnt_q + 16'd1;
          if (({1'b0, sample_cnt_q} + 17'd1) == {1'b0, len_q}) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_WAIT_IN;
          end
        end
`ifdef HOM_SEQ_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_W'(TIMEOUT)) begin
          err_d    = 1'b1;
          done_d   = 1'b1;
          dp_rst_d = 1'b0;
          state_d  = S_DONE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---- control / state registers ----
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      sample_cnt_q <= '0;
      done_q       <= 1'b0;
      dp_data_q    <= '0;
      dp_rst_q     <= 1'b0;
      clr_cnt_q    <= '0;
      push_vld_q   <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fill_q       <= '0;
`ifdef HOM_SEQ_TIMEOUT_EN
      tmo_cnt_q    <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      sample_cnt_q <= sample_cnt_d;
      done_q       <= done_d;
      dp_data_q    <= dp_data_d;
      dp_rst_q     <= dp_rst_d;
      clr_cnt_q    <= clr_cnt_d;
      push_vld_q   <= push_d;
      if (push_vld_q) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)        rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_vld_q, pop})
        2'b10:   fill_q <= fill_q + 1'b1;
        2'b01:   fill_q <= fill_q - 1'b1;
        default: fill_q <= fill_q;
      endcase
`ifdef HOM_SEQ_TIMEOUT_EN
      tmo_cnt_q    <= tmo_cnt_d;
      err_q        <= err_d;
`endif
    end
  end

  // ---- result staging and FIFO storage ----
  always_ff @(posedge clk_i) begin
    if (push_d)     push_data_q      <= bus.dp_out;
    if (push_vld_q) mem[wr_ptr_q]    <= push_data_q;
  end

endmodule
